bus_mux_reg: RTL and testbench

//  Parametrised, registered datapath bus source selector for the 9-bit processor.
//  - Selects one of NUM_REGS general registers, G, DIn or the ones constant onto Bus.
//  - Registers Bus, holds it when no source drives it, and reports conflicting drive

---
 rtl/proc_pkg.sv | 35 +++
 rtl/onehot_check.sv | 35 +++
 rtl/bus_mux_reg.sv | 125 ++++++++++++
 tb/tb_bus_mux_reg.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared constants for the 9-bit processor datapath: bus width, register count and
// the bus-source id encoding used by the bus selector and the control FSM.
package proc_pkg;

  localparam int BUS_W    = 9;
  localparam int NUM_REGS = 8;

  // Source ids follow the register ids, so they are derived from the register count.
  function automatic int srcG(input int numRegs);
    return numRegs;
  endfunction

  function automatic int srcDin(input int numRegs);
    return numRegs + 1;
  endfunction

  function automatic int srcOnes(input int numRegs);
    return numRegs + 2;
  endfunction

  function automatic int srcIdle(input int numRegs);
    return numRegs + 3;
  endfunction

  function automatic int srcW(input int numRegs);
    return $clog2(numRegs + 4);
  endfunction

  localparam int SRC_G    = srcG(NUM_REGS);
  localparam int SRC_DIN  = srcDin(NUM_REGS);
  localparam int SRC_ONES = srcOnes(NUM_REGS);
  localparam int SRC_IDLE = srcIdle(NUM_REGS);
  localparam int SRC_W    = srcW(NUM_REGS);

endpackage

// File: rtl/onehot_check.sv
// Classifies an N-bit enable vector as empty, one-hot or multi-hot and reports the
// position of the set bit; purely combinational so the control FSM can reuse it.
module onehot_check #(
  parameter  int N     = 8,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     vec,
  output logic             is_zero,
  output logic             is_onehot,
  output logic [IDX_W-1:0] index
);

  logic w_seen;
  logic w_multi;

  // index is only meaningful when exactly one bit is set.
  always_comb begin
    w_seen  = 1'b0;
    w_multi = 1'b0;
    index   = '0;
    for (int i = 0; i < N; i++) begin
      if (vec[i]) begin
        if (w_seen) begin
          w_multi = 1'b1;
        end
        w_seen = 1'b1;
        index  = IDX_W'(i);
      end
    end
  end

  assign is_zero   = ~w_seen;
  assign is_onehot = w_seen & ~w_multi;

endmodule

// File: rtl/bus_mux_reg.sv
// Registered bus source selector: priority-selects G, DIn, ones or one register onto
// Bus, holds Bus when idle, and tracks conflicting drive enables.
module bus_mux_reg #(
  parameter  int WIDTH    = proc_pkg::BUS_W,
  parameter  int NUM_REGS = proc_pkg::NUM_REGS,
  parameter  int CNT_W    = 4,
  localparam int SRC_W    = proc_pkg::srcW(NUM_REGS)
) (
  input  logic                      Clock,
  input  logic                      Resetn,
  input  logic [WIDTH-1:0]          DIn,
  input  logic [WIDTH-1:0]          G,
  input  logic [WIDTH-1:0]          ones,
  input  logic [NUM_REGS*WIDTH-1:0] R_flat,
  input  logic [NUM_REGS-1:0]       Rout,
  input  logic                      Gout,
  input  logic                      DIn_out,
  input  logic                      ones_out,
  input  logic                      err_clr,
  output logic [WIDTH-1:0]          Bus,
  output logic                      Bus_valid,
  output logic [SRC_W-1:0]          Bus_src,
  output logic                      conflict_err,
  output logic [CNT_W-1:0]          conflict_cnt
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  localparam logic [SRC_W-1:0] SRC_G_ID    = SRC_W'(proc_pkg::srcG(NUM_REGS));
  localparam logic [SRC_W-1:0] SRC_DIN_ID  = SRC_W'(proc_pkg::srcDin(NUM_REGS));
  localparam logic [SRC_W-1:0] SRC_ONES_ID = SRC_W'(proc_pkg::srcOnes(NUM_REGS));
  localparam logic [SRC_W-1:0] SRC_IDLE_ID = SRC_W'(proc_pkg::srcIdle(NUM_REGS));
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  logic             w_routZero;
  logic             w_routOneHot;
  logic [IDX_W-1:0] w_routIdx;
  logic [1:0]       w_fixedCount;
  logic             w_conflict;
  logic             w_load;
  logic [WIDTH-1:0] w_data;
  logic [SRC_W-1:0] w_src;

  logic [WIDTH-1:0] r_bus;
  logic             r_valid;
  logic [SRC_W-1:0] r_src;
  logic             r_err;
  logic [CNT_W-1:0] r_cnt;

  onehot_check #(
    .N(NUM_REGS)
  ) u_routCheck (
    .vec      (Rout),
    .is_zero  (w_routZero),
    .is_onehot(w_routOneHot),
    .index    (w_routIdx)
  );

  // A conflict is more than one enable set across the fixed sources and Rout combined.
  assign w_fixedCount = {1'b0, Gout} + {1'b0, DIn_out} + {1'b0, ones_out};
  assign w_conflict   = (w_fixedCount > 2'd1)
                      | ((w_fixedCount == 2'd1) & ~w_routZero)
                      | (~w_routZero & ~w_routOneHot);

  always_comb begin
    w_load = 1'b1;
    w_data = '0;
    w_src  = SRC_IDLE_ID;
    if (Gout) begin
      w_data = G;
      w_src  = SRC_G_ID;
    end else if (DIn_out) begin
      w_data = DIn;
      w_src  = SRC_DIN_ID;
    end else if (ones_out) begin
      w_data = ones;
      w_src  = SRC_ONES_ID;
    end else if (w_routOneHot) begin
      w_data = R_flat[int'(w_routIdx)*WIDTH +: WIDTH];
      w_src  = SRC_W'(w_routIdx);
    end else begin
      w_load = 1'b0;
    end
  end

  // Bus keeps its last value whenever nothing legitimately drives it.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_bus   <= '0;
      r_valid <= 1'b0;
      r_src   <= SRC_IDLE_ID;
    end else begin
      r_valid <= w_load;
      r_src   <= w_src;
      if (w_load) begin
        r_bus <= w_data;
      end
    end
  end

  // A conflict in the same cycle as a clear restarts the count at one.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_err <= 1'b0;
      r_cnt <= '0;
    end else if (w_conflict) begin
      r_err <= 1'b1;
      if (err_clr) begin
        r_cnt <= CNT_W'(1);
      end else if (r_cnt != CNT_MAX) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end else if (err_clr) begin
      r_err <= 1'b0;
      r_cnt <= '0;
    end
  end

  assign Bus          = r_bus;
  assign Bus_valid    = r_valid;
  assign Bus_src      = r_src;
  assign conflict_err = r_err;
  assign conflict_cnt = r_cnt;

endmodule

// File: tb/tb_bus_mux_reg.sv
// Directed bench for bus_mux_reg: a default 9-bit/8-register instance driven from a vector
// table plus corner sequences, and a 16-bit/16-register instance for the source sweep.
module tb_bus_mux_reg;

  logic clock = 1'b0;
  logic resetn = 1'b1;

  always #5 clock = ~clock;

  logic [8:0]  din8, g8, ones8;
  logic [71:0] rFlat8;
  logic [7:0]  rout8;
  logic        gout8, dinOut8, onesOut8, errClr8;
  logic [8:0]  bus8;
  logic        valid8, err8;
  logic [3:0]  src8, cnt8;

  logic [15:0]  din16, g16, ones16;
  logic [255:0] rFlat16;
  logic [15:0]  rout16;
  logic         gout16, dinOut16, onesOut16, errClr16;
  logic [15:0]  bus16;
  logic         valid16, err16;
  logic [4:0]   src16;
  logic [3:0]   cnt16;

  int checks = 0;
  int errors = 0;

  bus_mux_reg dut8 (
    .Clock(clock), .Resetn(resetn), .DIn(din8), .G(g8), .ones(ones8), .R_flat(rFlat8),
    .Rout(rout8), .Gout(gout8), .DIn_out(dinOut8), .ones_out(onesOut8), .err_clr(errClr8),
    .Bus(bus8), .Bus_valid(valid8), .Bus_src(src8), .conflict_err(err8), .conflict_cnt(cnt8)
  );

  bus_mux_reg #(.WIDTH(16), .NUM_REGS(16), .CNT_W(4)) dut16 (
    .Clock(clock), .Resetn(resetn), .DIn(din16), .G(g16), .ones(ones16), .R_flat(rFlat16),
    .Rout(rout16), .Gout(gout16), .DIn_out(dinOut16), .ones_out(onesOut16), .err_clr(errClr16),
    .Bus(bus16), .Bus_valid(valid16), .Bus_src(src16), .conflict_err(err16), .conflict_cnt(cnt16)
  );

  typedef struct {
    string      name;
    logic       gout;
    logic       dinOut;
    logic       onesOut;
    logic [7:0] rout;
    logic       errClr;
    logic [8:0] expBus;
    logic       expValid;
    logic [3:0] expSrc;
    logic       expErr;
    logic [3:0] expCnt;
  } vec_t;

  vec_t vecs[13];

  function automatic vec_t mkVec(input string name, input logic gout, input logic dinOut,
                                 input logic onesOut, input logic [7:0] rout, input logic errClr,
                                 input logic [8:0] expBus, input logic expValid,
                                 input logic [3:0] expSrc, input logic expErr,
                                 input logic [3:0] expCnt);
    vec_t v;
    v.name = name; v.gout = gout; v.dinOut = dinOut; v.onesOut = onesOut; v.rout = rout;
    v.errClr = errClr; v.expBus = expBus; v.expValid = expValid; v.expSrc = expSrc;
    v.expErr = expErr; v.expCnt = expCnt;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic check8(input string tag, input logic [8:0] expBus, input logic expValid,
                        input logic [3:0] expSrc, input logic expErr, input logic [3:0] expCnt);
    checkOutput({tag, ".Bus"}, 32'(bus8), 32'(expBus));
    checkOutput({tag, ".Bus_valid"}, 32'(valid8), 32'(expValid));
    checkOutput({tag, ".Bus_src"}, 32'(src8), 32'(expSrc));
    checkOutput({tag, ".conflict_err"}, 32'(err8), 32'(expErr));
    checkOutput({tag, ".conflict_cnt"}, 32'(cnt8), 32'(expCnt));
  endtask

  task automatic applyStimulus(input logic gout, input logic dinOut, input logic onesOut,
                               input logic [7:0] rout, input logic errClr);
    gout8 = gout; dinOut8 = dinOut; onesOut8 = onesOut; rout8 = rout; errClr8 = errClr;
    @(posedge clock);
    #1;
  endtask

  task automatic idle16();
    rout16 = '0; gout16 = 1'b0; dinOut16 = 1'b0; onesOut16 = 1'b0; errClr16 = 1'b0;
  endtask

  initial begin
    logic [31:0] rnd;

    din8 = 9'h100; g8 = 9'h0FF; ones8 = 9'h1FF;
    for (int i = 0; i < 8; i++) rFlat8[i*9 +: 9] = 9'h1A3 + 9'(i);
    din16 = 16'hD1D1; g16 = 16'h6A6A; ones16 = 16'hFFFF;
    for (int i = 0; i < 16; i++) rFlat16[i*16 +: 16] = 16'hA000 + 16'(i) * 16'h0111;
    gout8 = 1'b0; dinOut8 = 1'b0; onesOut8 = 1'b0; rout8 = '0; errClr8 = 1'b0;
    idle16();

    vecs[0]  = mkVec("v0_r2",       0, 0, 0, 8'h04, 0, 9'h1A5, 1, 4'd2,  0, 4'd0);
    vecs[1]  = mkVec("v1_idle",     0, 0, 0, 8'h00, 0, 9'h1A5, 0, 4'd11, 0, 4'd0);
    vecs[2]  = mkVec("v2_g_din",    1, 1, 0, 8'h00, 0, 9'h0FF, 1, 4'd8,  1, 4'd1);
    vecs[3]  = mkVec("v3_din",      0, 1, 0, 8'h00, 0, 9'h100, 1, 4'd9,  1, 4'd1);
    vecs[4]  = mkVec("v4_ones",     0, 0, 1, 8'h00, 0, 9'h1FF, 1, 4'd10, 1, 4'd1);
    vecs[5]  = mkVec("v5_r7",       0, 0, 0, 8'h80, 0, 9'h1AA, 1, 4'd7,  1, 4'd1);
    vecs[6]  = mkVec("v6_ones_r0",  0, 0, 1, 8'h01, 0, 9'h1FF, 1, 4'd10, 1, 4'd2);
    vecs[7]  = mkVec("v7_rmulti",   0, 0, 0, 8'h81, 0, 9'h1FF, 0, 4'd11, 1, 4'd3);
    vecs[8]  = mkVec("v8_clr",      0, 0, 0, 8'h00, 1, 9'h1FF, 0, 4'd11, 0, 4'd0);
    vecs[9]  = mkVec("v9_clr_conf", 0, 0, 0, 8'h03, 1, 9'h1FF, 0, 4'd11, 1, 4'd1);
    vecs[10] = mkVec("v10_all3",    1, 1, 1, 8'h00, 0, 9'h0FF, 1, 4'd8,  1, 4'd2);
    vecs[11] = mkVec("v11_r0",      0, 0, 0, 8'h01, 0, 9'h1A3, 1, 4'd0,  1, 4'd2);
    vecs[12] = mkVec("v12_clr_din", 0, 1, 0, 8'h00, 1, 9'h100, 1, 4'd9,  0, 4'd0);

    // Reset from X with no clock edge in between, then with inputs toggling.
    #2 resetn = 1'b0;
    #1;
    check8("reset_async", 9'h000, 1'b0, 4'd11, 1'b0, 4'd0);
    for (int k = 0; k < 4; k++) begin
      rnd = $urandom;
      gout8 = rnd[0]; dinOut8 = rnd[1]; onesOut8 = rnd[2]; rout8 = rnd[15:8]; errClr8 = rnd[3];
      @(posedge clock);
      #1;
    end
    check8("reset_toggle", 9'h000, 1'b0, 4'd11, 1'b0, 4'd0);
    checkOutput("reset16.Bus_src", 32'(src16), 32'd19);
    checkOutput("reset16.Bus_valid", 32'(valid16), 32'd0);
    gout8 = 1'b0; dinOut8 = 1'b0; onesOut8 = 1'b0; rout8 = '0; errClr8 = 1'b0;
    resetn = 1'b1;

    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].gout, vecs[i].dinOut, vecs[i].onesOut, vecs[i].rout, vecs[i].errClr);
      check8(vecs[i].name, vecs[i].expBus, vecs[i].expValid, vecs[i].expSrc,
             vecs[i].expErr, vecs[i].expCnt);
    end

    // Multi-hot Rout for 20 cycles: count climbs and sticks at 15, Bus holds.
    for (int k = 0; k < 20; k++) begin
      applyStimulus(0, 0, 0, 8'h81, 0);
      checkOutput($sformatf("sat_cnt_%0d", k), 32'(cnt8), (k + 1 < 15) ? 32'(k + 1) : 32'd15);
    end
    check8("sat_end", 9'h100, 1'b0, 4'd11, 1'b1, 4'd15);
    applyStimulus(0, 0, 0, 8'h00, 1);
    check8("sat_clr", 9'h100, 1'b0, 4'd11, 1'b0, 4'd0);

    // Mid-operation reset between clock edges.
    applyStimulus(0, 0, 1, 8'h03, 0);
    check8("pre_reset", 9'h1FF, 1'b1, 4'd10, 1'b1, 4'd1);
    #2 resetn = 1'b0;
    #1;
    check8("mid_reset", 9'h000, 1'b0, 4'd11, 1'b0, 4'd0);
    gout8 = 1'b0; onesOut8 = 1'b0; rout8 = '0;
    @(posedge clock);
    #1 resetn = 1'b1;
    applyStimulus(0, 0, 0, 8'h40, 0);
    check8("post_reset_r6", 9'h1A9, 1'b1, 4'd6, 1'b0, 4'd0);

    // Wide instance: every register in order, then G, DIn and ones.
    for (int i = 0; i < 16; i++) begin
      idle16();
      rout16 = 16'(1) << i;
      @(posedge clock);
      #1;
      checkOutput($sformatf("sweep_r%0d.Bus", i), 32'(bus16), 32'(16'hA000 + 16'(i) * 16'h0111));
      checkOutput($sformatf("sweep_r%0d.Bus_src", i), 32'(src16), 32'(i));
    end
    idle16(); gout16 = 1'b1;
    @(posedge clock); #1;
    checkOutput("sweep_g.Bus", 32'(bus16), 32'h6A6A);
    checkOutput("sweep_g.Bus_src", 32'(src16), 32'd16);
    idle16(); dinOut16 = 1'b1;
    @(posedge clock); #1;
    checkOutput("sweep_din.Bus", 32'(bus16), 32'hD1D1);
    checkOutput("sweep_din.Bus_src", 32'(src16), 32'd17);
    idle16(); onesOut16 = 1'b1;
    @(posedge clock); #1;
    checkOutput("sweep_ones.Bus", 32'(bus16), 32'hFFFF);
    checkOutput("sweep_ones.Bus_src", 32'(src16), 32'd18);
    checkOutput("sweep_ones.Bus_valid", 32'(valid16), 32'd1);
    checkOutput("sweep.conflict_cnt", 32'(cnt16), 32'd0);
    idle16();
    @(posedge clock); #1;
    checkOutput("sweep_idle.Bus", 32'(bus16), 32'hFFFF);
    checkOutput("sweep_idle.Bus_src", 32'(src16), 32'd19);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
